// File: rtl/teleprinter_sequencer_if.sv
// Bundle between main control / store readout and the teleprinter sequencer.
// The control side (master) presents O orders and sees the handshake and
// line status; the sequencer (slave) owns the serial line and status flags.
interface teleprinter_sequencer_if #(
   parameter int CHAR_W = 5
);
   logic              op_o;
   logic [CHAR_W-1:0] char_in;
   logic              ord_ack;
   logic              stop_one_c;
   logic              prt_busy;
   logic              tp_line;
   logic              char_done;
   logic [2:0]        bit_idx;

   modport master (
      output op_o, char_in,
      input  ord_ack, stop_one_c, prt_busy, tp_line, char_done, bit_idx
   );

   modport slave (
      input  op_o, char_in,
      output ord_ack, stop_one_c, prt_busy, tp_line, char_done, bit_idx
   );
endinterface

// File: rtl/teleprinter_sequencer.sv
// EDSAC output teleprinter sequencer.
// Accepts a character on an O order, serialises it as one start bit (space),
// CHAR_W code bits LSB first and STOP_BITS stop periods (mark), and stalls
// main control while a further O order waits for the line to become free.
module teleprinter_sequencer #(
   parameter int BIT_TICKS = 16,
   parameter int STOP_BITS = 2,
   parameter int CHAR_W    = 5
) (
   input  logic                    clk,
   input  logic                    rst,
   teleprinter_sequencer_if.slave  bus
);

   localparam int TICK_W = (BIT_TICKS > 1) ? $clog2(BIT_TICKS) : 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      BITS  = 2'd2,
      STOP  = 2'd3
   } state_t;

   state_t              state_q, state_d;
   logic [TICK_W-1:0]   tick_q, tick_d;
   // Counts code bits in BITS and stop periods in STOP.
   logic [2:0]          bit_q, bit_d;
   logic [CHAR_W-1:0]   char_q;
   logic                load_char;
   logic                ack_q, ack_d;
   logic                done_q, done_d;
   logic                tick_last;
   logic                line;

   assign tick_last = (tick_q == TICK_W'(BIT_TICKS - 1));

   // State, counters, latched character and the two registered pulses.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         tick_q  <= '0;
         bit_q   <= '0;
         char_q  <= '0;
         ack_q   <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         tick_q  <= tick_d;
         bit_q   <= bit_d;
         ack_q   <= ack_d;
         done_q  <= done_d;
         if (load_char) begin
            char_q <= bus.char_in;
         end
      end
   end

   // Next-state logic: the tick counter restarts at every state or bit change.
   always_comb begin
      state_d   = state_q;
      tick_d    = tick_q;
      bit_d     = bit_q;
      load_char = 1'b0;
      ack_d     = 1'b0;
      done_d    = 1'b0;
      unique case (state_q)
         IDLE: begin
            tick_d = '0;
            bit_d  = '0;
            if (bus.op_o) begin
               state_d   = START;
               load_char = 1'b1;
               ack_d     = 1'b1;
            end
         end
         START: begin
            if (tick_last) begin
               state_d = BITS;
               tick_d  = '0;
               bit_d   = '0;
            end else begin
               tick_d = tick_q + TICK_W'(1);
            end
         end
         BITS: begin
            if (tick_last) begin
               tick_d = '0;
               if (bit_q == 3'(CHAR_W - 1)) begin
                  state_d = STOP;
                  bit_d   = '0;
               end else begin
                  bit_d = bit_q + 3'd1;
               end
            end else begin
               tick_d = tick_q + TICK_W'(1);
            end
         end
         STOP: begin
            if (tick_last) begin
               tick_d = '0;
               if (bit_q == 3'(STOP_BITS - 1)) begin
                  state_d = IDLE;
                  bit_d   = '0;
                  done_d  = 1'b1;
               end else begin
                  bit_d = bit_q + 3'd1;
               end
            end else begin
               tick_d = tick_q + TICK_W'(1);
            end
         end
         default: begin
            state_d = IDLE;
            tick_d  = '0;
            bit_d   = '0;
         end
      endcase
   end

   // Line level follows the state directly so a reset returns it to mark at once.
   always_comb begin
      line = 1'b1;
      unique case (state_q)
         IDLE:    line = 1'b1;
         START:   line = 1'b0;
         BITS:    line = char_q[bit_q];
         STOP:    line = 1'b1;
         default: line = 1'b1;
      endcase
   end

   assign bus.tp_line    = line;
   assign bus.prt_busy   = (state_q != IDLE);
   assign bus.ord_ack    = ack_q;
   assign bus.char_done  = done_q;
   assign bus.bit_idx    = (state_q == BITS) ? bit_q : 3'd0;
   // Pending order while busy stalls control; it clears the cycle IDLE is reached.
   assign bus.stop_one_c = bus.op_o & (state_q != IDLE) & ~rst;

endmodule
